// File: rtl/bsg_print_stat_snoop_mc.sv
// Snoops num_ch_p host-link store streams for print-stat stores, timestamps them into
// per-channel FIFOs and drains them round-robin to one record port.
// Define BSG_PRINT_STAT_SNOOP_DROP_CNT_EN to build the saturating drop counter.
module bsg_print_stat_snoop_mc #(
    parameter int num_ch_p = 4,
    parameter int addr_width_p = 28,
    parameter int data_width_p = 32,
    parameter int ctr_width_p = 64,
    parameter int fifo_els_p = 4,
    parameter logic [addr_width_p-1:0] print_stat_addr_p = 'h0_1000,
    localparam int ch_width_lp = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             enable_i,
    input  logic [num_ch_p-1:0]              pkt_v_i,
    input  logic [num_ch_p*addr_width_p-1:0] pkt_addr_i,
    input  logic [num_ch_p*data_width_p-1:0] pkt_data_i,
    input  logic [ctr_width_p-1:0]           ctr_i,
    output logic                             stat_v_o,
    input  logic                             stat_ready_i,
    output logic [ch_width_lp-1:0]           stat_ch_o,
    output logic [data_width_p-1:0]          stat_tag_o,
    output logic [ctr_width_p-1:0]           stat_time_o,
    output logic                             pending_o,
    output logic [15:0]                      drop_cnt_o
);

    localparam int ptr_width_lp = $clog2(fifo_els_p);

    // Pointers carry one extra wrap bit so a full FIFO differs from an empty one.
    logic [ptr_width_lp:0]   head_q [num_ch_p];
    logic [ptr_width_lp:0]   head_d [num_ch_p];
    logic [ptr_width_lp:0]   tail_q [num_ch_p];
    logic [ptr_width_lp:0]   tail_d [num_ch_p];
    logic [data_width_p-1:0] tag_mem_q  [num_ch_p][fifo_els_p];
    logic [ctr_width_p-1:0]  time_mem_q [num_ch_p][fifo_els_p];

    logic                    stat_v_q, stat_v_d;
    logic [ch_width_lp-1:0]  stat_ch_q, stat_ch_d;
    logic [data_width_p-1:0] stat_tag_q, stat_tag_d;
    logic [ctr_width_p-1:0]  stat_time_q, stat_time_d;
    logic [ch_width_lp-1:0]  last_grant_q, last_grant_d;

    logic [num_ch_p-1:0]     match, full, empty, push, pop;
    logic [ch_width_lp-1:0]  grant, grant_hi, grant_lo;
    logic                    found_hi, any_ne, load_en, load;

    always_comb begin
        for (int c = 0; c < num_ch_p; c++) begin
            match[c] = enable_i & pkt_v_i[c]
                     & (pkt_addr_i[c*addr_width_p +: addr_width_p] == print_stat_addr_p);
            empty[c] = (head_q[c] == tail_q[c]);
            full[c]  = (head_q[c][ptr_width_lp] != tail_q[c][ptr_width_lp])
                     && (head_q[c][ptr_width_lp-1:0] == tail_q[c][ptr_width_lp-1:0]);
            push[c]  = match[c] & ~full[c];
        end
    end

    assign any_ne  = ~&empty;
    assign load_en = ~stat_v_q | stat_ready_i;
    assign load    = load_en & any_ne;

    // Round-robin: lowest non-empty channel above last_grant, else lowest non-empty overall.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_hi = '0;
        grant_lo = '0;
        found_hi = 1'b0;
        for (int c = num_ch_p - 1; c >= 0; c--) begin
            if (!empty[c]) begin
                grant_lo = ch_width_lp'(c);
                if (ch_width_lp'(c) > last_grant_q) begin
                    grant_hi = ch_width_lp'(c);
                    found_hi = 1'b1;
                end
            end
        end
        grant = found_hi ? grant_hi : grant_lo;
        for (int c = 0; c < num_ch_p; c++) begin
            pop[c] = load && (grant == ch_width_lp'(c));
        end
    end

    always_comb begin
        stat_v_d     = stat_v_q;
        stat_ch_d    = stat_ch_q;
        stat_tag_d   = stat_tag_q;
        stat_time_d  = stat_time_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            stat_v_d = any_ne;
        end
        if (load) begin
            stat_ch_d    = grant;
            stat_tag_d   = tag_mem_q[grant][head_q[grant][ptr_width_lp-1:0]];
            stat_time_d  = time_mem_q[grant][head_q[grant][ptr_width_lp-1:0]];
            last_grant_d = grant;
        end
        for (int c = 0; c < num_ch_p; c++) begin
            head_d[c] = head_q[c] + (ptr_width_lp+1)'(pop[c]);
            tail_d[c] = tail_q[c] + (ptr_width_lp+1)'(push[c]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < num_ch_p; c++) begin
                head_q[c] <= '0;
                tail_q[c] <= '0;
            end
            stat_v_q     <= 1'b0;
            stat_ch_q    <= '0;
            stat_tag_q   <= '0;
            stat_time_q  <= '0;
            last_grant_q <= ch_width_lp'(num_ch_p - 1);
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            stat_v_q     <= stat_v_d;
            stat_ch_q    <= stat_ch_d;
            stat_tag_q   <= stat_tag_d;
            stat_time_q  <= stat_time_d;
            last_grant_q <= last_grant_d;
        end
    end

    // NOTE: record storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < num_ch_p; c++) begin
            if (push[c]) begin
                tag_mem_q[c][tail_q[c][ptr_width_lp-1:0]]  <= pkt_data_i[c*data_width_p +: data_width_p];
                time_mem_q[c][tail_q[c][ptr_width_lp-1:0]] <= ctr_i;
            end
        end
    end

`ifdef BSG_PRINT_STAT_SNOOP_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    // One extra sum bit is enough to detect saturation for any practical channel count.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int c = 0; c < num_ch_p; c++) begin
            drop_sum = drop_sum + 17'(match[c] & full[c]);
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = 16'h0;
`endif

    assign stat_v_o    = stat_v_q;
    assign stat_ch_o   = stat_ch_q;
    assign stat_tag_o  = stat_tag_q;
    assign stat_time_o = stat_time_q;
    assign pending_o   = stat_v_q | any_ne;

endmodule

// File: tb/tb_bsg_print_stat_snoop_mc.sv
// Self-checking bench for bsg_print_stat_snoop_mc: scoreboard of expected records plus
// a vector table for the match filter and hand sequences for latency, arbitration and drops.
module tb_bsg_print_stat_snoop_mc;

    localparam int num_ch_lp = 4;
    localparam int aw_lp     = 28;
    localparam int dw_lp     = 32;
    localparam logic [27:0] ps_addr_lp = 28'h000_1000;
`ifdef BSG_PRINT_STAT_SNOOP_DROP_CNT_EN
    localparam bit drop_en_lp = 1'b1;
`else
    localparam bit drop_en_lp = 1'b0;
`endif

    logic                          clk_i;
    logic                          reset_n_i;
    logic                          enable_i;
    logic [num_ch_lp-1:0]          pkt_v_i;
    logic [num_ch_lp*aw_lp-1:0]    pkt_addr_i;
    logic [num_ch_lp*dw_lp-1:0]    pkt_data_i;
    logic [63:0]                   ctr_i;
    logic                          stat_v_o;
    logic                          stat_ready_i;
    logic [1:0]                    stat_ch_o;
    logic [31:0]                   stat_tag_o;
    logic [63:0]                   stat_time_o;
    logic                          pending_o;
    logic [15:0]                   drop_cnt_o;

    bsg_print_stat_snoop_mc dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
        .pkt_v_i(pkt_v_i), .pkt_addr_i(pkt_addr_i), .pkt_data_i(pkt_data_i),
        .ctr_i(ctr_i), .stat_v_o(stat_v_o), .stat_ready_i(stat_ready_i),
        .stat_ch_o(stat_ch_o), .stat_tag_o(stat_tag_o), .stat_time_o(stat_time_o),
        .pending_o(pending_o), .drop_cnt_o(drop_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] tag;
        logic [63:0] tm;
    } rec_t;

    typedef struct {
        logic        en;
        logic [3:0]  v;
        logic [27:0] addr;
        int          exp_n;
    } vec_t;

    rec_t sb[$];
    logic [1:0] emit_ch[$];
    int emit_cyc[$];
    int cyc;
    int total;
    int bad;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumes a record if one fires this cycle, then advances one clock.
    task automatic tick();
        int idx;
        idx = -1;
        if (reset_n_i && stat_v_o && stat_ready_i) begin
            emit_ch.push_back(stat_ch_o);
            emit_cyc.push_back(cyc);
            for (int i = 0; i < sb.size(); i++) begin
                if (idx < 0 && sb[i].ch == stat_ch_o) idx = i;
            end
            check("sb_hit", 128'(idx >= 0), 128'(1));
            if (idx >= 0) begin
                check("record", {30'h0, stat_ch_o, stat_tag_o, stat_time_o},
                      {30'h0, sb[idx].ch, sb[idx].tag, sb[idx].tm});
                sb.delete(idx);
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        ctr_i = ctr_i + 64'd7;
    endtask

    task automatic drive(input int ch, input logic [27:0] addr, input logic [31:0] tag,
                         input bit accept);
        rec_t r;
        pkt_v_i[ch] = 1'b1;
        pkt_addr_i[ch*aw_lp +: aw_lp] = addr;
        pkt_data_i[ch*dw_lp +: dw_lp] = tag;
        if (accept) begin
            r.ch  = 2'(ch);
            r.tag = tag;
            r.tm  = ctr_i;
            sb.push_back(r);
        end
    endtask

    task automatic clear_pkts();
        pkt_v_i    = '0;
        pkt_addr_i = '0;
        pkt_data_i = '0;
        enable_i   = 1'b1;
    endtask

    task automatic clear_emits();
        emit_ch.delete();
        emit_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        clear_pkts();
        tick();
        tick();
        reset_n_i = 1'b1;
        sb.delete();
        clear_emits();
    endtask

    initial begin
        vec_t vecs[8];
        logic [63:0] t0;
        logic [31:0] tag0;
        int m;

        vecs[0] = '{1'b1, 4'b0001, 28'h000_1000, 1};
        vecs[1] = '{1'b1, 4'b1111, 28'h000_1000, 4};
        vecs[2] = '{1'b1, 4'b0100, 28'h000_1001, 0};
        vecs[3] = '{1'b0, 4'b1111, 28'h000_1000, 0};
        vecs[4] = '{1'b1, 4'b0000, 28'h000_1000, 0};
        vecs[5] = '{1'b1, 4'b1010, 28'h000_0000, 0};
        vecs[6] = '{1'b1, 4'b1010, 28'h000_1000, 2};
        vecs[7] = '{1'b1, 4'b0001, 28'h800_1000, 0};

        total = 0;
        bad = 0;
        cyc = 0;
        ctr_i = 64'h1234_5678_0000_0000;
        stat_ready_i = 1'b1;
        clear_pkts();
        do_reset();

        // Reset state
        check("rst_v", 128'(stat_v_o), 128'(0));
        check("rst_pending", 128'(pending_o), 128'(0));
        check("rst_out", {30'h0, stat_ch_o, stat_tag_o, stat_time_o}, 128'(0));
        check("rst_drop", 128'(drop_cnt_o), 128'(0));

        // Single record: two-cycle latency, timestamp of the match cycle
        t0 = ctr_i;
        drive(0, ps_addr_lp, 32'hA5, 1'b1);
        tick();
        clear_pkts();
        check("lat1_v", 128'(stat_v_o), 128'(0));
        check("lat1_pending", 128'(pending_o), 128'(1));
        tick();
        check("lat2_v", 128'(stat_v_o), 128'(1));
        check("lat2_rec", {30'h0, stat_ch_o, stat_tag_o, stat_time_o}, {30'h0, 2'd0, 32'hA5, t0});
        tick();
        check("single_pending", 128'(pending_o), 128'(0));
        check("single_count", 128'(emit_ch.size()), 128'(1));

        // Round-robin after reset: 0,1,2,3 back to back, then 1 before 2
        do_reset();
        m = cyc;
        for (int c = 0; c < 4; c++) drive(c, ps_addr_lp, 32'h100 + 32'(c), 1'b1);
        tick();
        clear_pkts();
        repeat (8) tick();
        check("rr_count", 128'(emit_ch.size()), 128'(4));
        if (emit_ch.size() == 4) begin
            check("rr_first_cyc", 128'(emit_cyc[0]), 128'(m + 2));
            for (int i = 0; i < 4; i++) begin
                check("rr_order", 128'(emit_ch[i]), 128'(i));
                check("rr_back2back", 128'(emit_cyc[i]), 128'(emit_cyc[0] + i));
            end
        end
        clear_emits();
        drive(2, ps_addr_lp, 32'h202, 1'b1);
        drive(1, ps_addr_lp, 32'h201, 1'b1);
        tick();
        clear_pkts();
        repeat (6) tick();
        check("rr2_count", 128'(emit_ch.size()), 128'(2));
        if (emit_ch.size() == 2) begin
            check("rr2_first", 128'(emit_ch[0]), 128'(1));
            check("rr2_second", 128'(emit_ch[1]), 128'(2));
        end

        // Backpressure and overflow on ch2: 1 in output, 4 in FIFO, 1 dropped
        stat_ready_i = 1'b0;
        clear_emits();
        t0 = ctr_i;
        tag0 = 32'hB000;
        for (int i = 0; i < 6; i++) begin
            drive(2, ps_addr_lp, 32'hB000 + 32'(i), i < 5);
            tick();
            clear_pkts();
        end
        check("bp_drop", 128'(drop_cnt_o), drop_en_lp ? 128'(1) : 128'(0));
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_v", 128'(stat_v_o), 128'(1));
            check("bp_stall_rec", {30'h0, stat_ch_o, stat_tag_o, stat_time_o},
                  {30'h0, 2'd2, tag0, t0});
            tick();
        end
        stat_ready_i = 1'b1;
        repeat (10) tick();
        check("bp_drain_count", 128'(emit_ch.size()), 128'(5));
        check("bp_pending", 128'(pending_o), 128'(0));

        // Reset mid-operation: buffered records vanish, match in reset cycle ignored
        stat_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, ps_addr_lp, 32'hD00 + 32'(i), 1'b0);
            tick();
            clear_pkts();
        end
        reset_n_i = 1'b0;
        drive(3, ps_addr_lp, 32'hDEAD, 1'b0);
        tick();
        reset_n_i = 1'b1;
        clear_pkts();
        check("mid_rst_v", 128'(stat_v_o), 128'(0));
        check("mid_rst_pending", 128'(pending_o), 128'(0));
        check("mid_rst_out", {30'h0, stat_ch_o, stat_tag_o, stat_time_o}, 128'(0));
        check("mid_rst_drop", 128'(drop_cnt_o), 128'(0));
        stat_ready_i = 1'b1;
        clear_emits();
        repeat (5) tick();
        check("mid_rst_no_stale", 128'(emit_ch.size()), 128'(0));
        drive(0, ps_addr_lp, 32'h77, 1'b1);
        tick();
        clear_pkts();
        repeat (4) tick();
        check("mid_rst_new_count", 128'(emit_ch.size()), 128'(1));

        // Filter table: address and enable qualification
        for (int i = 0; i < 8; i++) begin
            enable_i = vecs[i].en;
            for (int c = 0; c < 4; c++) begin
                if (vecs[i].v[c]) drive(c, vecs[i].addr, 32'hC000_0000 + 32'(i*16 + c), vecs[i].exp_n != 0);
            end
            tick();
            clear_pkts();
            clear_emits();
            repeat (8) tick();
            check("vec_count", 128'(emit_ch.size()), 128'(vecs[i].exp_n));
            check("vec_pending", 128'(pending_o), 128'(0));
            check("vec_drop", 128'(drop_cnt_o), 128'(0));
        end
        check("sb_empty", 128'(sb.size()), 128'(0));

        // Saturation: every channel matches every cycle with the consumer stalled
        do_reset();
        stat_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) drive(c, ps_addr_lp, 32'hE000 + 32'(c), 1'b0);
        repeat (10) tick();
        check("sat_exact", 128'(drop_cnt_o), drop_en_lp ? 128'(23) : 128'(0));
        repeat (17490) tick();
        check("sat_hold", 128'(drop_cnt_o), drop_en_lp ? 128'(16'hFFFF) : 128'(0));
        do_reset();
        check("sat_rst_drop", 128'(drop_cnt_o), 128'(0));
        check("sat_rst_pending", 128'(pending_o), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
